dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the core's load/store port (cpu) and a debug/loader port (dbg). Arbitrates per cycle and drives the memory address, write data and write enable from the winner. Tags each read with its requester and returns read data after a fixed latency. Raises a stall to the program sequencer while the core is denied. A debug lock mode gives the dbg port exclusive access for atomic sequences.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles (>=1)
MAX_WAIT, 4, consecutive denied dbg cycles before dbg is forced to win (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; block is held in reset while 0
cpu_req  in  1  core access request; held with addr/we/wdata until cpu_gnt
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  core address
cpu_wdata  in  DATA_W  core store data
cpu_gnt  out  1  request accepted this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  DATA_W  load data to core
cpu_stall  out  1  cpu_req & ~cpu_gnt
dbg_req  in  1  debug request; same hold rule
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_lock  in  1  request exclusive bus ownership
dbg_gnt  out  1  request accepted this cycle
dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid
dbg_rdata  out  DATA_W  read data to debug
mem_address  out  ADDR_W  to data memory
mem_write_data  out  DATA_W  to data memory
mem_write_enable  out  1  to data memory
mem_rdata  in  DATA_W  from data memory, valid RD_LAT cycles after address

Behaviour:
- Reset (reset=0): state OPEN, wait counter 0, tag pipeline cleared. All outputs 0: both gnt, both rvalid, stall, mem_* and both rdata.
- Grant is combinational from the current inputs and registered state. At most one gnt per cycle. The granted request is accepted in that same cycle.
- Priority in state OPEN:
  - cpu wins.
  - Exception: dbg wins if wait_cnt==MAX_WAIT.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or when dbg_req=0.
- With MAX_WAIT=4 and both requesting continuously, dbg is granted on the 5th cycle. cpu then regains priority.
- FSM:
  - OPEN -> LOCKED when dbg_gnt & dbg_lock.
  - LOCKED: cpu is never granted; dbg is granted whenever dbg_req=1.
  - LOCKED -> OPEN on any cycle dbg_lock=0, regardless of dbg_req. The OPEN rules apply from the next cycle.
- Memory drive:
  - mem_address and mem_write_data come from the winner.
  - mem_write_enable = winner_we & grant.
  - No grant: address/data 0, write_enable 0.
- Writes complete in the grant cycle and produce no rvalid.
- Reads:
  - A tag {valid, id} enters an RD_LAT-deep shift pipeline on a read grant.
  - When the tag exits, the matching rvalid pulses for 1 cycle and that rdata = mem_rdata. The other rdata holds its last value.
- Back-to-back reads are allowed every cycle. Return order equals grant order.
- Reset asserted mid-read: in-flight tags are discarded, no rvalid after reset release.
- cpu_stall = cpu_req & ~cpu_gnt, combinational. It is 1 for every denied cycle, including all of LOCKED.

Decomposition:
- Shared package smips_pkg:
  - requester_id_t enum {REQ_CPU, REQ_DBG}
  - arb_state_t enum {ARB_OPEN, ARB_LOCKED}
  - rd_tag_t struct {valid, id}
- Sub-module rd_tag_pipe, parameterised by RD_LAT: shifts rd_tag_t and outputs the exiting tag. Same clk/reset.

Test Plan:
- Hold reset=0 with all req=1 -> every output 0. Release reset, cpu_req read addr 0x10 -> cpu_gnt=1, mem_address=0x10. cpu_rvalid pulses 1 cycle later with mem_rdata value 0xDEADBEEF on cpu_rdata.
- cpu_req store 0x20/0x1234 and dbg_req together -> cpu_gnt=1, mem_write_enable=1, mem_write_data=0x1234. dbg_gnt=0, no rvalid.
- Both req held continuously, MAX_WAIT=4 -> grants cpu,cpu,cpu,cpu,dbg,cpu. dbg_rvalid (not cpu_rvalid) on the dbg read's return cycle.
- dbg_req+dbg_lock granted, cpu_req=1 for 6 cycles -> cpu_gnt=0 and cpu_stall=1 throughout. Drop dbg_lock -> cpu_gnt=1 next cycle.
- RD_LAT=3, alternating cpu/dbg reads every cycle -> rvalids return in grant order, each exactly 3 cycles after its grant, routed to the correct port.
- cpu read granted, then reset=0 for 1 cycle before data return -> no cpu_rvalid ever appears; outputs 0 during reset.

Source files
------------

// File: rtl/smips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smips_pkg
// Description : Types and constants shared by the data-memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package smips_pkg;

  // Identifies which requester owns a memory access.
  typedef enum logic [0:0] {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } requester_id_t;

  // Arbiter ownership mode.
  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Read tag travelling alongside an outstanding memory read.
  typedef struct packed {
    logic          valid;
    requester_id_t id;
  } rd_tag_t;

  localparam rd_tag_t c_TAG_IDLE = '{valid: 1'b0, id: REQ_CPU};

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_tag_pipe
// Description : RD_LAT-deep shift pipeline of read tags; presents the tag
//               whose read data is on the memory bus this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
  import smips_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t r_stage [RD_LAT];

  // Shift tags one stage per cycle; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_stage[i] <= c_TAG_IDLE;
      end
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign tag_out = r_stage[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the core load/store
//               port and the debug/loader port, with starvation guard for
//               debug, a debug lock mode, and tagged fixed-latency read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import smips_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                  c_WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_next;
  logic                w_cpu_gnt;
  logic                w_dbg_gnt;
  rd_tag_t             w_tag_in;
  rd_tag_t             w_tag_out;
  logic                w_cpu_rvalid;
  logic                w_dbg_rvalid;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;

  // State and debug-starvation counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB_OPEN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // Grant decision and next state; nothing is granted while reset is held.
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_dbg_gnt    = 1'b0;
    w_state_next = r_state;
    if (reset) begin
      case (r_state)
        ARB_OPEN: begin
          // A starved debug request overrides the core's normal priority.
          if (dbg_req && (r_wait_cnt == c_WAIT_MAX)) begin
            w_dbg_gnt = 1'b1;
          end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (dbg_req) begin
            w_dbg_gnt = 1'b1;
          end
          if (w_dbg_gnt && dbg_lock) begin
            w_state_next = ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          w_dbg_gnt = dbg_req;
          if (!dbg_lock) begin
            w_state_next = ARB_OPEN;
          end
        end
        default: w_state_next = ARB_OPEN;
      endcase
    end
  end

  // Count consecutive denied debug cycles, saturating at MAX_WAIT.
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (!dbg_req || w_dbg_gnt) begin
      w_wait_next = '0;
    end else if (r_wait_cnt != c_WAIT_MAX) begin
      w_wait_next = r_wait_cnt + c_WAIT_W'(1);
    end
  end

  // Route the winner onto the memory bus and build its read tag.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    w_tag_in         = c_TAG_IDLE;
    if (w_cpu_gnt) begin
      mem_address      = cpu_addr;
      mem_write_data   = cpu_wdata;
      mem_write_enable = cpu_we;
      w_tag_in.valid   = ~cpu_we;
      w_tag_in.id      = REQ_CPU;
    end else if (w_dbg_gnt) begin
      mem_address      = dbg_addr;
      mem_write_data   = dbg_wdata;
      mem_write_enable = dbg_we;
      w_tag_in.valid   = ~dbg_we;
      w_tag_in.id      = REQ_DBG;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  assign w_cpu_rvalid = w_tag_out.valid && (w_tag_out.id == REQ_CPU);
  assign w_dbg_rvalid = w_tag_out.valid && (w_tag_out.id == REQ_DBG);

  // Hold the most recent read data of each port between returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_cpu_rvalid) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_dbg_rvalid) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign cpu_rvalid = w_cpu_rvalid;
  assign dbg_rvalid = w_dbg_rvalid;
  assign cpu_rdata  = w_cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dbg_rdata  = w_dbg_rvalid ? mem_rdata : r_dbg_rdata;
  assign cpu_stall  = reset & cpu_req & ~w_cpu_gnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter; instance 0 uses RD_LAT=1,
//               instance 1 uses RD_LAT=3. Both use MAX_WAIT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_gnt [2];
  logic        cpu_rvalid [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_stall [2];
  logic        dbg_req [2];
  logic        dbg_we [2];
  logic [31:0] dbg_addr [2];
  logic [31:0] dbg_wdata [2];
  logic        dbg_lock [2];
  logic        dbg_gnt [2];
  logic        dbg_rvalid [2];
  logic [31:0] dbg_rdata [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_write_data [2];
  logic        mem_write_enable [2];
  logic [31:0] mem_rdata [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit finish_req = 1'b0;
  bit mon_done   = 1'b0;

  // Memory contents as seen by the bench.
  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 ^ a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] ma [3];
    always @(posedge clk) begin
      ma[0] <= mem_address[g];
      ma[1] <= ma[0];
      ma[2] <= ma[1];
    end
    assign mem_rdata[g] = fdata(ma[LAT-1]);

    dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .MAX_WAIT(4)
    ) u_dut (
      .clk(clk), .reset(reset_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_stall(cpu_stall[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_lock(dbg_lock[g]), .dbg_gnt(dbg_gnt[g]),
      .dbg_rvalid(dbg_rvalid[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_address(mem_address[g]), .mem_write_data(mem_write_data[g]),
      .mem_write_enable(mem_write_enable[g]), .mem_rdata(mem_rdata[g])
    );
  end

  typedef struct {
    bit          cg;
    bit          dg;
    bit          stall;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
  } cyc_exp_t;

  typedef struct {
    bit          dbg;
    logic [31:0] data;
    int          cyc;
  } ret_exp_t;

  cyc_exp_t cq0 [$];
  cyc_exp_t cq1 [$];
  ret_exp_t rq0 [$];
  ret_exp_t rq1 [$];

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input int i,
                       input bit creq, input bit cwe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input bit dreq, input bit dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd,
                       input bit dlock, input bit ecg, input bit edg,
                       input bit track_ret = 1'b1);
    cyc_exp_t e;
    ret_exp_t r;
    @(posedge clk); #1;
    cpu_req[i] = creq;  cpu_we[i] = cwe;  cpu_addr[i] = caddr; cpu_wdata[i] = cwd;
    dbg_req[i] = dreq;  dbg_we[i] = dwe;  dbg_addr[i] = daddr; dbg_wdata[i] = dwd;
    dbg_lock[i] = dlock;
    e.cg    = ecg;
    e.dg    = edg;
    e.stall = creq & ~ecg;
    e.we    = ecg ? cwe   : (edg ? dwe   : 1'b0);
    e.addr  = ecg ? caddr : (edg ? daddr : 32'h0);
    e.wd    = ecg ? cwd   : (edg ? dwd   : 32'h0);
    if (i == 0) cq0.push_back(e); else cq1.push_back(e);
    if (track_ret && ((ecg && !cwe) || (edg && !dwe))) begin
      r.dbg  = edg;
      r.data = fdata(ecg ? caddr : daddr);
      r.cyc  = cyc + ((i == 0) ? 1 : 3);
      if (i == 0) rq0.push_back(r); else rq1.push_back(r);
    end
  endtask

  task automatic idle(input int i);
    drive(i, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic set_inputs(input int i, input bit v);
    cpu_req[i] = v;  cpu_we[i] = v;  cpu_addr[i] = v ? 32'hA0 : 32'h0;
    cpu_wdata[i] = v ? 32'h77 : 32'h0;
    dbg_req[i] = v;  dbg_we[i] = 1'b0; dbg_addr[i] = v ? 32'hB0 : 32'h0;
    dbg_wdata[i] = v ? 32'h99 : 32'h0; dbg_lock[i] = v;
  endtask

  initial begin
    reset_n = 1'b0;
    set_inputs(0, 1'b1);
    set_inputs(1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_inputs(0, 1'b0);
    set_inputs(1, 1'b0);

    // First read after reset returns 0xDEADBEEF to the core.
    drive(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    idle(0);

    // Store wins over a simultaneous debug read; debug served afterwards.
    drive(0, 1, 1, 32'h20, 32'h1234, 1, 0, 32'h30, 32'h0, 0, 1, 0);
    drive(0, 0, 0, 32'h0,  32'h0,    1, 0, 32'h30, 32'h0, 0, 0, 1);
    idle(0);
    idle(0);

    // Continuous contention: cpu x4, dbg on the 5th, then cpu again.
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 32'h100 + 32'(4 * k), 32'h0,
            1, 0, (k < 5) ? 32'h200 : 32'h204, 32'h0, 0, (k != 4), (k == 4));
    end
    idle(0);
    idle(0);

    // Debug lock: core starved until the lock is dropped.
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h55, 1, 0, 1);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 32'h50, 32'h0, (k % 2 == 0), 1, 32'h44 + 32'(4 * k),
            32'h60 + 32'(k), 1, 0, (k % 2 == 0));
    end
    drive(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    idle(0);
    idle(0);

    // RD_LAT=3: alternating cpu/dbg reads every cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        drive(1, 1, 0, 32'h300 + 32'(4 * k), 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
      else
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h400 + 32'(4 * k), 32'h0, 0, 0, 1);
    end
    repeat (4) idle(1);

    // Reset while a read is in flight: its data must never be returned.
    drive(1, 1, 0, 32'h500, 32'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_inputs(1, 1'b0);
    repeat (5) idle(1);

    @(posedge clk);
    finish_req = 1'b1;
    for (int t = 0; t < 10 && !mon_done; t++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not finish, required done");
      $fatal(1, "monitor timeout");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ----------------------------------------------------------------- monitor
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i);
    cyc_exp_t e;
    ret_exp_t r;
    bit       have;
    if (!reset_n) begin
      chk($sformatf("inst%0d reset_outputs", i),
          {cpu_gnt[i], dbg_gnt[i], cpu_rvalid[i], dbg_rvalid[i], cpu_stall[i],
           mem_write_enable[i], |mem_address[i], |mem_write_data[i],
           |cpu_rdata[i], |dbg_rdata[i]}, 64'h0);
      return;
    end
    have = (i == 0) ? (cq0.size() > 0) : (cq1.size() > 0);
    if (have) begin
      if (i == 0) e = cq0.pop_front(); else e = cq1.pop_front();
      chk($sformatf("inst%0d cpu_gnt", i),   cpu_gnt[i],          e.cg);
      chk($sformatf("inst%0d dbg_gnt", i),   dbg_gnt[i],          e.dg);
      chk($sformatf("inst%0d cpu_stall", i), cpu_stall[i],        e.stall);
      chk($sformatf("inst%0d mem_we", i),    mem_write_enable[i], e.we);
      chk($sformatf("inst%0d mem_addr", i),  mem_address[i],      e.addr);
      chk($sformatf("inst%0d mem_wdata", i), mem_write_data[i],   e.wd);
    end
    have = (i == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
    if (cpu_rvalid[i] || dbg_rvalid[i]) begin
      chk($sformatf("inst%0d single_rvalid", i), cpu_rvalid[i] & dbg_rvalid[i], 64'h0);
      if (!have) begin
        chk($sformatf("inst%0d unexpected_rvalid", i), {cpu_rvalid[i], dbg_rvalid[i]}, 64'h0);
      end else begin
        if (i == 0) r = rq0.pop_front(); else r = rq1.pop_front();
        chk($sformatf("inst%0d ret_port", i), dbg_rvalid[i], r.dbg);
        chk($sformatf("inst%0d ret_data", i), r.dbg ? dbg_rdata[i] : cpu_rdata[i], r.data);
        chk($sformatf("inst%0d ret_cycle", i), cyc, r.cyc);
      end
    end else if (have) begin
      r = (i == 0) ? rq0[0] : rq1[0];
      if (r.cyc <= cyc) begin
        if (i == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
        chk($sformatf("inst%0d missing_rvalid", i), {cpu_rvalid[i], dbg_rvalid[i]},
            r.dbg ? 64'h1 : 64'h2);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_done) begin
        if (finish_req) begin
          chk("cycle_queue_drained", cq0.size() + cq1.size(), 64'h0);
          chk("return_queue_drained", rq0.size() + rq1.size(), 64'h0);
          mon_done = 1'b1;
        end else begin
          mon(0);
          mon(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
